// File: rtl/seq_detect_pkg.sv
// Shared definitions for the parametrised serial-pattern detector:
// control-state encoding, reset configuration and MAX_LEN legality bounds.
package seq_detect_pkg;

  // Control state, derived from how many history bits are valid for matching
  typedef enum logic [1:0] {
    StEmpty   = 2'd0,  // fill == 0
    StFilling = 2'd1,  // 0 < fill < len
    StArmed   = 2'd2   // fill >= len
  } seqdet_state_e;

  // Reset configuration reproduces the legacy 10101 overlapping detector
  localparam logic [4:0]  RST_PATTERN = 5'b10101;
  localparam int unsigned RST_LEN     = 5;
  localparam logic        RST_OVERLAP = 1'b1;

  // Supported range for the MAX_LEN parameter
  localparam int unsigned MAX_LEN_MIN = 5;
  localparam int unsigned MAX_LEN_MAX = 32;

  // Map a fill level onto the control state for a given pattern length
  function automatic seqdet_state_e fill_state(input int unsigned fill, input int unsigned len);
    if (fill == 0) begin
      return StEmpty;
    end else if (fill >= len) begin
      return StArmed;
    end else begin
      return StFilling;
    end
  endfunction

endpackage

// File: rtl/seqdet_sat_cnt.sv
// Saturating up-counter with synchronous reset and synchronous clear.
// Clear takes priority over increment; the count holds at all-ones.
module seqdet_sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count register: reset/clear to zero, otherwise saturating increment
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised Moore serial-pattern detector with runtime-programmable
// pattern (1..MAX_LEN bits), overlapping / non-overlapping detection and a
// sticky configuration-error flag.
// Optional feature: define SEQDET_MATCH_CNT_EN to build the saturating match
// counter; otherwise match_cnt is tied to zero and no counter flops exist.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_bit,
  input  logic                         cfg_we,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  output logic                         match,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         cfg_err
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MaxFill = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  seqdet_state_e      state_q, state_d;
  logic               match_q, match_d;
  logic               cfg_err_q, cfg_err_d;

  logic               cfg_legal;
  logic               shift_en;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic [MAX_LEN-1:0] len_mask;
  logic               detect;

  // Next-state logic: configuration writes take priority over the data bit
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    state_d   = state_q;
    match_d   = 1'b0;
    cfg_err_d = cfg_err_q;

    cfg_legal = (cfg_len != '0) && (cfg_len <= MaxFill);
    // A bit arriving with a config write is dropped, legal write or not
    shift_en  = in_valid && !cfg_we;

    // Shift written as a full-width operation so the outgoing MSB is simply lost
    hist_next = (hist_q << 1) | MAX_LEN'(in_bit);

    unique case (state_q)
      StEmpty: fill_next = LEN_W'(1);
      default: fill_next = (fill_q == MaxFill) ? fill_q : fill_q + LEN_W'(1);
    endcase

    // Only the low len bits of history and pattern take part in the compare
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end

    detect = shift_en && (fill_next >= len_q) && (((hist_next ^ pattern_q) & len_mask) == '0);

    if (cfg_we) begin
      if (cfg_legal) begin
        pattern_d = cfg_pattern;
        len_d     = cfg_len;
        overlap_d = cfg_overlap;
        fill_d    = '0;
        state_d   = StEmpty;
        cfg_err_d = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (shift_en) begin
      hist_d  = hist_next;
      match_d = detect;
      if (detect && !overlap_q) begin
        // Non-overlapping: bits consumed by this match cannot start the next
        fill_d  = '0;
        state_d = StEmpty;
      end else begin
        fill_d  = fill_next;
        state_d = fill_state(int'(fill_next), int'(len_q));
      end
    end
  end

  // State registers with synchronous reset to the legacy 10101 configuration
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= MAX_LEN'(RST_PATTERN);
      len_q     <= LEN_W'(RST_LEN);
      overlap_q <= RST_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      state_q   <= StEmpty;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      state_q   <= state_d;
      match_q   <= match_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign match   = match_q;
  assign cfg_err = cfg_err_q;

`ifdef SEQDET_MATCH_CNT_EN
  logic cnt_clr;
  assign cnt_clr = cfg_we && cfg_legal;

  seqdet_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .inc(detect),
    .cnt(match_cnt)
  );
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param. A bit-queue reference model
// predicts match / match_cnt / cfg_err each cycle; predictions are queued
// before the clock edge and compared against the DUT after it. A second
// instance with CNT_W = 2 shares all inputs to observe counter saturation.
module tb_seq_detect_param;

  localparam int unsigned MaxLen = 8;
  localparam int unsigned LenW   = $clog2(MaxLen + 1);
`ifdef SEQDET_MATCH_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_bit = 1'b0;
  logic              cfg_we = 1'b0;
  logic [MaxLen-1:0] cfg_pattern = '0;
  logic [LenW-1:0]   cfg_len = '0;
  logic              cfg_overlap = 1'b0;
  logic              match, match2;
  logic [15:0]       match_cnt;
  logic [1:0]        match_cnt2;
  logic              cfg_err, cfg_err2;

  always #5 clk = ~clk;

  seq_detect_param #(
    .MAX_LEN(MaxLen),
    .CNT_W  (16)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .match      (match),
    .match_cnt  (match_cnt),
    .cfg_err    (cfg_err)
  );

  seq_detect_param #(
    .MAX_LEN(MaxLen),
    .CNT_W  (2)
  ) u_dut_w2 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .match      (match2),
    .match_cnt  (match_cnt2),
    .cfg_err    (cfg_err2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: bits received since fill was last cleared (newest at back)
  bit          m_bits[$];
  logic [7:0]  m_pat;
  int unsigned m_len;
  bit          m_ovl;
  int unsigned m_cnt;
  int unsigned m_cnt2;
  bit          m_err;
  bit          m_match;

  typedef struct {
    logic        m;
    logic [15:0] c;
    logic [1:0]  c2;
    logic        e;
  } exp_t;

  exp_t sb[$];

  function automatic void model_reset();
    m_bits.delete();
    m_pat   = 8'b0001_0101;
    m_len   = 5;
    m_ovl   = 1'b1;
    m_cnt   = 0;
    m_cnt2  = 0;
    m_err   = 1'b0;
    m_match = 1'b0;
  endfunction

  function automatic void model_step();
    bit det;
    m_match = 1'b0;
    if (rst) begin
      model_reset();
    end else if (cfg_we) begin
      if (cfg_len >= 1 && int'(cfg_len) <= int'(MaxLen)) begin
        m_pat  = cfg_pattern;
        m_len  = cfg_len;
        m_ovl  = cfg_overlap;
        m_bits.delete();
        m_cnt  = 0;
        m_cnt2 = 0;
        m_err  = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else if (in_valid) begin
      m_bits.push_back(in_bit);
      if (m_bits.size() > MaxLen) void'(m_bits.pop_front());
      det = (m_bits.size() >= m_len);
      for (int i = 0; i < int'(m_len); i++) begin
        if (det && m_bits[m_bits.size() - 1 - i] != m_pat[i]) det = 1'b0;
      end
      m_match = det;
      if (det) begin
        if (m_cnt != 32'hFFFF) m_cnt++;
        if (m_cnt2 != 3) m_cnt2++;
        if (!m_ovl) m_bits.delete();
      end
    end
  endfunction

  // One clock: predict, push, clock, pop and compare, then drop strobes
  task automatic cyc(input string tag);
    exp_t e;
    exp_t got;
    model_step();
    e.m  = m_match;
    e.c  = CntEn ? 16'(m_cnt) : 16'd0;
    e.c2 = CntEn ? 2'(m_cnt2) : 2'd0;
    e.e  = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check_val({tag, ".match"}, 32'(match), 32'(got.m));
    check_val({tag, ".cnt"}, 32'(match_cnt), 32'(got.c));
    check_val({tag, ".err"}, 32'(cfg_err), 32'(got.e));
    check_val({tag, ".cnt_w2"}, 32'(match_cnt2), 32'(got.c2));
    rst      = 1'b0;
    cfg_we   = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send_bit(input string tag, input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    cyc(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  task automatic write_cfg(input string tag, input logic [7:0] p, input logic [LenW-1:0] l,
                           input logic o);
    cfg_we      = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cyc(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc("reset");
  endtask

  logic [8:0] stream9;
  int         n_match;

  initial begin
    model_reset();
    stream9 = 9'b1_0101_0101;

    // Reset defaults, including reset asserted from an unknown power-up
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    check_val("rst_match", 32'(match), 32'd0);
    check_val("rst_cnt", 32'(match_cnt), 32'd0);
    check_val("rst_err", 32'(cfg_err), 32'd0);

    // Legacy overlapping 10101 on 101010101: matches after bits 5, 7, 9
    n_match = 0;
    for (int i = 8; i >= 0; i--) begin
      send_bit("ovl", stream9[i]);
      n_match += int'(match);
    end
    check_val("ovl_nmatch", 32'(n_match), 32'd3);
    check_val("ovl_cnt", 32'(match_cnt), CntEn ? 32'd3 : 32'd0);

    // Non-overlapping: one match in the 9-bit stream, a second in the next burst
    do_reset();
    write_cfg("cfg_novl", 8'b0001_0101, LenW'(5), 1'b0);
    n_match = 0;
    for (int i = 8; i >= 0; i--) begin
      send_bit("novl", stream9[i]);
      n_match += int'(match);
    end
    for (int i = 4; i >= 0; i--) begin
      send_bit("novl2", stream9[i]);
      n_match += int'(match);
    end
    check_val("novl_nmatch", 32'(n_match), 32'd2);
    check_val("novl_cnt", 32'(match_cnt), CntEn ? 32'd2 : 32'd0);

    // Sparse valids: match exactly one cycle wide, then held low while idle
    do_reset();
    for (int i = 4; i >= 0; i--) begin
      send_bit("sparse", stream9[i]);
      if (i == 0) check_val("sparse_hit", 32'(match), 32'd1);
      idle("sparse_idle", 3);
    end
    check_val("sparse_low", 32'(match), 32'd0);

    // Reconfigure mid-stream: old history must not produce a match
    do_reset();
    send_bit("pre", 1'b1);
    send_bit("pre", 1'b0);
    send_bit("pre", 1'b1);
    send_bit("pre", 1'b0);
    write_cfg("cfg_110", 8'b1111_0110, LenW'(3), 1'b1);
    send_bit("p110", 1'b1);
    send_bit("p110", 1'b1);
    check_val("p110_early", 32'(match), 32'd0);
    send_bit("p110", 1'b0);
    check_val("p110_hit", 32'(match), 32'd1);
    check_val("p110_cnt", 32'(match_cnt), CntEn ? 32'd1 : 32'd0);

    // Illegal writes: error flag set, default config retained
    do_reset();
    write_cfg("bad0", 8'hFF, LenW'(0), 1'b0);
    check_val("bad0_err", 32'(cfg_err), 32'd1);
    write_cfg("bad9", 8'hFF, LenW'(MaxLen + 1), 1'b0);
    check_val("bad9_err", 32'(cfg_err), 32'd1);
    // Bit arriving with an illegal write is dropped
    in_valid = 1'b1;
    in_bit   = 1'b1;
    write_cfg("bad_drop", 8'hFF, LenW'(0), 1'b0);
    for (int i = 4; i >= 0; i--) send_bit("bad_dflt", stream9[i]);
    check_val("bad_dflt_hit", 32'(match), 32'd1);
    write_cfg("good", 8'b0000_0001, LenW'(1), 1'b1);
    check_val("good_err", 32'(cfg_err), 32'd0);

    // Reset mid-stream clears a would-be match
    do_reset();
    for (int i = 4; i >= 1; i--) send_bit("rst_mid", stream9[i]);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    rst      = 1'b1;
    cyc("rst_mid_edge");
    check_val("rst_mid_match", 32'(match), 32'd0);

    // len 1, upper pattern bits ignored: six back-to-back matches, CNT_W=2 saturates
    write_cfg("cfg_len1", 8'b1010_1011, LenW'(1), 1'b1);
    for (int i = 0; i < 6; i++) begin
      send_bit("len1", 1'b1);
      check_val("len1_match", 32'(match2), 32'd1);
    end
    check_val("len1_cnt_w2", 32'(match_cnt2), CntEn ? 32'd3 : 32'd0);
    check_val("len1_cnt", 32'(match_cnt), CntEn ? 32'd6 : 32'd0);
    send_bit("len1_zero", 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        write_cfg("rnd_cfg", 8'($urandom), LenW'($urandom_range(0, MaxLen + 1)),
                  1'($urandom));
      end else if ($urandom_range(0, 3) == 0) begin
        idle("rnd_idle", 1);
      end else begin
        send_bit("rnd", 1'($urandom_range(0, 1)));
      end
    end

    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
